ysyx_23060025_axi_sram: RTL and testbench

AXI4-style responder (slave) memory for the NPC simulation fabric: it receives the core's instruction-fetch read bursts and LSU single-beat reads and writes and returns data, last, and response signals. It holds a word-organised SRAM array behind independent read and write state machines. It has a configurable read latency and per-beat out-of-range error reporting. One instance can sit behind each of the core's fetch and data masters, or behind an arbiter.

---
 rtl/ysyx_23060025_axi_sram.sv | 209 ++++++++++++++++++++
 tb/tb_ysyx_23060025_axi_sram.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_axi_sram.sv
// AXI4-style responder memory: word-organised byte-lane SRAM behind independent
// read (INCR bursts, configurable latency) and write (single-beat) channels.
`timescale 1ns/1ps
module ysyx_23060025_axi_sram #(
    parameter int                  ADDR_LEN    = 32,
    parameter int                  DATA_LEN    = 32,
    parameter logic [ADDR_LEN-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                  DEPTH_WORDS = 4096,
    parameter int                  RD_LAT      = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_LEN-1:0] araddr,
    input  logic                arvalid,
    output logic                arready,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    output logic [DATA_LEN-1:0] rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_LEN-1:0] awaddr,
    input  logic [2:0]          awsize,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_LEN-1:0] wdata,
    input  logic [3:0]          wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);
    localparam int                  NB        = DATA_LEN / 8;
    localparam int                  IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_LEN-1:0] SPAN      = ADDR_LEN'(DEPTH_WORDS) << 2;
    localparam int                  WCW       = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam int                  WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

    // Offset arithmetic wraps below BASE_ADDR, so one unsigned compare covers both bounds.
    function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
        return (a - BASE_ADDR) < SPAN;
    endfunction

    // Beat size is not used: the full aligned word is always returned or written.
    logic unused_size;
    assign unused_size = ^{arsize, awsize};

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    r_state_t            r_state_reg, r_state_next;
    logic [ADDR_LEN-1:0] r_addr_reg, r_addr_next;
    logic [7:0]          r_len_reg, r_len_next;
    logic [7:0]          r_beat_reg, r_beat_next;
    logic [WCW-1:0]      r_wait_reg, r_wait_next;
    logic                r_err_reg;
    logic                fetch_en;
    logic [ADDR_LEN-1:0] fetch_addr;
    logic [IDX_W-1:0]    fetch_idx;
    logic [DATA_LEN-1:0] mem_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_reg <= R_IDLE;
            r_wait_reg  <= '0;
            r_err_reg   <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            r_wait_reg  <= r_wait_next;
            if (fetch_en) begin
                r_err_reg <= !in_range(fetch_addr);
            end
        end
    end

    always_ff @(posedge clock) begin
        r_addr_reg <= r_addr_next;
        r_len_reg  <= r_len_next;
        r_beat_reg <= r_beat_next;
    end

    // The word for the next visible beat is fetched on the edge that makes it visible.
    always_comb begin
        r_state_next = r_state_reg;
        r_addr_next  = r_addr_reg;
        r_len_next   = r_len_reg;
        r_beat_next  = r_beat_reg;
        r_wait_next  = r_wait_reg;
        fetch_en     = 1'b0;
        fetch_addr   = r_addr_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (arvalid && arready) begin
                    r_addr_next = araddr;
                    r_len_next  = arlen;
                    r_beat_next = 8'd0;
                    r_wait_next = '0;
                    if (RD_LAT == 1) begin
                        r_state_next = R_DATA;
                        fetch_en     = 1'b1;
                        fetch_addr   = araddr;
                    end else begin
                        r_state_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_wait_reg == WCW'(WAIT_LAST)) begin
                    r_state_next = R_DATA;
                    fetch_en     = 1'b1;
                    fetch_addr   = r_addr_reg;
                end else begin
                    r_wait_next = r_wait_reg + 1'b1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (r_beat_reg == r_len_reg) begin
                        r_state_next = R_IDLE;
                    end else begin
                        r_beat_next = r_beat_reg + 8'd1;
                        r_addr_next = r_addr_reg + ADDR_LEN'(4);
                        fetch_en    = 1'b1;
                        fetch_addr  = r_addr_reg + ADDR_LEN'(4);
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign fetch_idx = IDX_W'((fetch_addr - BASE_ADDR) >> 2);
    assign arready   = (r_state_reg == R_IDLE) && !reset;
    assign rvalid    = (r_state_reg == R_DATA);
    assign rlast     = rvalid && (r_beat_reg == r_len_reg);
    assign rresp     = (rvalid && r_err_reg) ? 2'b10 : 2'b00;
    assign rdata     = (rvalid && !r_err_reg) ? mem_q : '0;

    logic                aw_got_reg, w_got_reg, bvalid_reg;
    logic [1:0]          bresp_reg;
    logic [ADDR_LEN-1:0] aw_addr_reg;
    logic [DATA_LEN-1:0] w_data_reg;
    logic [3:0]          w_strb_reg;
    logic                aw_hs, w_hs, commit, wr_ok, wr_en;
    logic [ADDR_LEN-1:0] wr_addr;
    logic [DATA_LEN-1:0] wr_data;
    logic [3:0]          wr_strb;
    logic [IDX_W-1:0]    wr_idx;

    assign awready = !aw_got_reg && !bvalid_reg && !reset;
    assign wready  = !w_got_reg && !bvalid_reg && !reset;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    // Commit on the edge that completes the pair, taking whichever half arrives now.
    assign wr_addr = aw_got_reg ? aw_addr_reg : awaddr;
    assign wr_data = w_got_reg ? w_data_reg : wdata;
    assign wr_strb = w_got_reg ? w_strb_reg : wstrb;
    assign commit  = (aw_got_reg || aw_hs) && (w_got_reg || w_hs) && !reset;
    assign wr_ok   = in_range(wr_addr);
    assign wr_en   = commit && wr_ok;
    assign wr_idx  = IDX_W'((wr_addr - BASE_ADDR) >> 2);
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_got_reg <= 1'b0;
            w_got_reg  <= 1'b0;
            bvalid_reg <= 1'b0;
            bresp_reg  <= 2'b00;
        end else if (commit) begin
            aw_got_reg <= 1'b0;
            w_got_reg  <= 1'b0;
            bvalid_reg <= 1'b1;
            bresp_reg  <= wr_ok ? 2'b00 : 2'b10;
        end else begin
            if (aw_hs) aw_got_reg <= 1'b1;
            if (w_hs) w_got_reg <= 1'b1;
            if (bvalid_reg && bready) bvalid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (aw_hs) aw_addr_reg <= awaddr;
        if (w_hs) begin
            w_data_reg <= wdata;
            w_strb_reg <= wstrb;
        end
    end

    // One byte-wide array per lane; non-blocking read gives old data on a same-edge write.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_q_reg;
            always_ff @(posedge clock) begin
                if (wr_en && wr_strb[gi]) begin
                    lane_mem[wr_idx] <= wr_data[8*gi +: 8];
                end
                if (fetch_en) begin
                    lane_q_reg <= lane_mem[fetch_idx];
                end
            end
            assign mem_q[8*gi +: 8] = lane_q_reg;
        end
    endgenerate
endmodule

// File: tb/tb_ysyx_23060025_axi_sram.sv
// Bench for ysyx_23060025_axi_sram: transaction-level memory model compared every
// cycle, directed scenarios with literal expectations, then random concurrent traffic.
`timescale 1ns/1ps
module tb_ysyx_23060025_axi_sram;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH  = 64;
    localparam int          RD_LAT = 1;
    localparam int          TMO    = 200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic [2:0]  awsize = 3'd2;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ysyx_23060025_axi_sram #(
        .ADDR_LEN(32), .DATA_LEN(32), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen), .arsize(arsize),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_rd_act = 0;
    int          m_rd_wait, m_len, m_beat;
    logic [31:0] m_start, m_data;
    logic [1:0]  m_resp;
    bit          m_aw_got = 0, m_w_got = 0, m_bvalid = 0;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;

    function automatic bit mapped(input logic [31:0] a);
        longint unsigned ua, lo;
        ua = longint'(a & 32'hFFFF_FFFC);
        lo = longint'(BASE);
        return (ua >= lo) && (ua < lo + 64'(4 * DEPTH));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic void model_fetch(input logic [31:0] a);
        if (mapped(a)) begin
            m_data = m_mem[word_of(a)];
            m_resp = 2'b00;
        end else begin
            m_data = '0;
            m_resp = 2'b10;
        end
    endfunction

    always @(negedge clock) begin : model_cmp
        bit e_arready, e_rvalid, e_rlast, e_awready, e_wready;
        e_arready = !reset && !m_rd_act;
        e_rvalid  = m_rd_act && (m_rd_wait == 0);
        e_rlast   = e_rvalid && (m_beat == m_len);
        e_awready = !reset && !m_aw_got && !m_bvalid;
        e_wready  = !reset && !m_w_got && !m_bvalid;
        check("arready", arready, e_arready);
        check("rvalid", rvalid, e_rvalid);
        if (e_rvalid) begin
            check("rdata", rdata, m_data);
            check("rresp", rresp, m_resp);
            check("rlast", rlast, e_rlast);
        end
        check("awready", awready, e_awready);
        check("wready", wready, e_wready);
        check("bvalid", bvalid, m_bvalid);
        if (m_bvalid) check("bresp", bresp, m_bresp);

        if (reset) begin
            m_rd_act = 0; m_aw_got = 0; m_w_got = 0; m_bvalid = 0;
        end else begin
            // read side first: a fetch on this edge sees memory before this edge's write
            if (e_rvalid) begin
                if (rready) begin
                    if (m_beat == m_len) m_rd_act = 0;
                    else begin
                        m_beat++;
                        model_fetch(m_start + 32'(4 * m_beat));
                    end
                end
            end else if (m_rd_act) begin
                m_rd_wait--;
                if (m_rd_wait == 0) model_fetch(m_start + 32'(4 * m_beat));
            end else if (arvalid) begin
                m_rd_act = 1; m_start = araddr; m_len = int'(arlen); m_beat = 0;
                m_rd_wait = RD_LAT - 1;
                if (m_rd_wait == 0) model_fetch(araddr);
            end
            if (m_bvalid) begin
                if (bready) m_bvalid = 0;
            end else begin
                if (awvalid && e_awready) begin m_aw_got = 1; m_awaddr = awaddr; end
                if (wvalid && e_wready) begin m_w_got = 1; m_wdata = wdata; m_wstrb = wstrb; end
                if (m_aw_got && m_w_got) begin
                    if (mapped(m_awaddr)) begin
                        for (int b = 0; b < 4; b++)
                            if (m_wstrb[b]) m_mem[word_of(m_awaddr)][8*b +: 8] = m_wdata[8*b +: 8];
                        m_bresp = 2'b00;
                    end else m_bresp = 2'b10;
                    m_bvalid = 1; m_aw_got = 0; m_w_got = 0;
                end
            end
        end
    end

    // ---------------- stimulus tasks (enter and leave at posedge+1) ----------------
    logic [31:0] rd_d [256];
    logic [1:0]  rd_r [256];
    logic        rd_l [256];
    int          rd_n;

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic ar_phase(input logic [31:0] a, input logic [7:0] len);
        int n = 0;
        araddr = a; arlen = len; arvalid = 1'b1;
        @(negedge clock);
        while (!arready && n < TMO) begin @(negedge clock); n++; end
        if (n >= TMO) check("ar_handshake_timeout", 32'(n), 32'(0));
        tick(); arvalid = 1'b0;
    endtask

    task automatic aw_phase(input logic [31:0] a);
        int n = 0;
        awaddr = a; awvalid = 1'b1;
        @(negedge clock);
        while (!awready && n < TMO) begin @(negedge clock); n++; end
        if (n >= TMO) check("aw_handshake_timeout", 32'(n), 32'(0));
        tick(); awvalid = 1'b0;
    endtask

    task automatic w_phase(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        @(negedge clock);
        while (!wready && n < TMO) begin @(negedge clock); n++; end
        if (n >= TMO) check("w_handshake_timeout", 32'(n), 32'(0));
        tick(); wvalid = 1'b0;
    endtask

    task automatic b_phase(input int mode, output logic [1:0] resp);
        int n = 0;
        bit got = 0;
        resp = 2'bxx;
        while (!got && n < TMO) begin
            bready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clock);
            if (bvalid && bready) begin resp = bresp; got = 1; end
            tick(); n++;
        end
        bready = 1'b0;
        if (!got) check("b_handshake_timeout", 32'(n), 32'(0));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int order, input int bmode, output logic [1:0] resp);
        case (order)
            0: fork aw_phase(a); w_phase(d, s); join
            1: begin aw_phase(a); w_phase(d, s); end
            default: begin w_phase(d, s); aw_phase(a); end
        endcase
        b_phase(bmode, resp);
    endtask

    // mode 0: rready high, 1: toggling 1,0,1,0..., 2: random
    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input int mode);
        int n = 0;
        bit tog = 1;
        ar_phase(a, len);
        rd_n = 0;
        while (rd_n <= int'(len) && n < TMO) begin
            case (mode)
                0: rready = 1'b1;
                1: rready = tog;
                default: rready = ($urandom_range(0, 3) != 0);
            endcase
            tog = !tog;
            @(negedge clock);
            if (rvalid && rready) begin
                rd_d[rd_n] = rdata; rd_r[rd_n] = rresp; rd_l[rd_n] = rlast; rd_n++;
            end
            tick(); n++;
        end
        rready = 1'b0;
        check("read_beat_count", 32'(rd_n), 32'(int'(len) + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] resp;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            do_write(BASE + 32'(4 * i), 32'hA500_0000 | 32'(i), 4'hF, i % 3, 0, resp);

        // single read
        do_write(BASE, 32'hDEAD_BEEF, 4'hF, 0, 0, resp);
        check("single_bresp", resp, 2'b00);
        do_read(BASE, 8'd0, 0);
        check("single_rdata", rd_d[0], 32'hDEAD_BEEF);
        check("single_rlast", rd_l[0], 1'b1);
        check("single_rresp", rd_r[0], 2'b00);

        // burst with backpressure
        for (int k = 0; k < 4; k++) do_write(BASE + 32'h10 + 32'(4 * k), 32'(k + 1), 4'hF, 1, 0, resp);
        do_read(BASE + 32'h10, 8'd3, 1);
        for (int k = 0; k < 4; k++) begin
            check("burst_rdata", rd_d[k], 32'(k + 1));
            check("burst_rlast", rd_l[k], (k == 3) ? 1'b1 : 1'b0);
        end

        // strobed write, W before AW
        do_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
        do_write(BASE + 32'h20, 32'h1122_3344, 4'b0101, 2, 0, resp);
        check("strobe_bresp", resp, 2'b00);
        do_read(BASE + 32'h20, 8'd0, 0);
        check("strobe_rdata", rd_d[0], 32'hFF22_FF44);

        // out of range
        do_read(BASE + 32'(4 * DEPTH) - 32'd4, 8'd1, 0);
        check("oor_b0_rresp", rd_r[0], 2'b00);
        check("oor_b0_rdata", rd_d[0], 32'hA500_003F);
        check("oor_b1_rresp", rd_r[1], 2'b10);
        check("oor_b1_rdata", rd_d[1], 32'h0);
        check("oor_b1_rlast", rd_l[1], 1'b1);
        do_write(BASE - 32'd4, 32'h0, 4'hF, 0, 0, resp);
        check("oor_bresp", resp, 2'b10);
        do_read(BASE + 32'(4 * DEPTH) - 32'd4, 8'd0, 0);
        check("oor_mem_kept", rd_d[0], 32'hA500_003F);

        // reset mid-burst with a pending B
        fork aw_phase(BASE + 32'h8); w_phase(32'h55, 4'hF); join
        ar_phase(BASE, 8'd7);
        rready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("rst_arready", arready, 1'b0);
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        tick();
        reset = 1'b0; rready = 1'b0;
        @(negedge clock);
        check("post_rst_rvalid", rvalid, 1'b0);
        check("post_rst_bvalid", bvalid, 1'b0);
        check("post_rst_arready", arready, 1'b1);
        check("post_rst_awready", awready, 1'b1);
        check("post_rst_wready", wready, 1'b1);
        tick();
        do_read(BASE, 8'd0, 0);
        check("post_rst_read", rd_d[0], 32'hDEAD_BEEF);
        aw_phase(BASE + 32'hC);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("partial_aw_dropped", awready, 1'b1);
        tick();

        // same-edge read fetch and write commit on one word
        fork
            do_read(BASE + 32'h30, 8'd0, 0);
            begin
                fork aw_phase(BASE + 32'h30); w_phase(32'h0BAD_F00D, 4'hF); join
                b_phase(0, resp);
            end
        join
        check("collision_old", rd_d[0], 32'hA500_000C);
        do_read(BASE + 32'h30, 8'd0, 0);
        check("collision_new", rd_d[0], 32'h0BAD_F00D);

        // random concurrent traffic
        fork
            for (int i = 0; i < 60; i++) begin
                int k;
                logic [31:0] a;
                k = int'($urandom_range(0, DEPTH + 7)) - 4;
                a = BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
                do_read(a, 8'($urandom_range(0, 7)), 2);
                if ($urandom_range(0, 1) == 1) tick();
            end
            for (int i = 0; i < 60; i++) begin
                int k;
                logic [1:0] wr_resp;
                k = int'($urandom_range(0, DEPTH + 7)) - 4;
                do_write(BASE + 32'(4 * k), $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 2)), 1, wr_resp);
                if ($urandom_range(0, 2) == 0) tick();
            end
        join
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
